// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (1 start, DATA bits LSB first, [parity with UART_RX_PARITY_EN], 1 stop).
// Latency: rec_ready/frame_err/parity_err pulse 1 sys_clk after the stop-bit sampling tick.
// Backpressure: none; rec_data holds until the next good frame and must be consumed within one frame time.
module uart_rx_os #(
  parameter int DATA = 8,
  parameter int OS   = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst_l,
  input  logic            baud_tick,
  input  logic            rx,
  output logic [DATA-1:0] rec_data,
  output logic            rec_ready,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);

  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DATA + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [DATA-1:0] shift_reg, shift_nxt;
  logic [DATA-1:0] rec_data_nxt;
  logic            rec_ready_nxt, frame_err_nxt;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_nxt;
  logic            parity_err_nxt;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst_l) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rec_data  <= '0;
      rec_ready <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      rec_data  <= rec_data_nxt;
      rec_ready <= rec_ready_nxt;
      frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_nxt;
      parity_err <= parity_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_nxt      = tick_cnt;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift_reg;
    rec_data_nxt  = rec_data;
    rec_ready_nxt = 1'b0;
    frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt        = par_bit;
    parity_err_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Start edge is taken on rx_s alone so a frame can follow the stop sample immediately
        if (!rx_s) begin
          state_nxt = S_START;
          tick_nxt  = '0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_HALF) begin
            if (!rx_s) begin
              state_nxt = S_DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            shift_nxt = {rx_s, shift_reg[DATA-1:1]};
            tick_nxt  = '0;
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            par_nxt   = rx_s;
            tick_nxt  = '0;
            state_nxt = S_STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (rx_s) begin
              state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift_reg, par_bit}) begin
                parity_err_nxt = 1'b1;
              end else begin
                rec_ready_nxt = 1'b1;
                rec_data_nxt  = shift_reg;
              end
`else
              rec_ready_nxt = 1'b1;
              rec_data_nxt  = shift_reg;
`endif
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = S_BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it never looks like a new start bit
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: OS=16, baud_tick every 4 sys_clk, so one bit period is 64 sys_clk.
module tb_uart_rx_os;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_l = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] rec_data;
  logic       rec_ready;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  int vectors  = 0;
  int errors   = 0;
  int rdy_cnt  = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] got[$];
  logic [1:0] tdiv = 2'd0;

  uart_rx_os #(.DATA(8), .OS(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rec_data  (rec_data),
    .rec_ready (rec_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    tdiv      <= tdiv + 2'd1;
    baud_tick <= (tdiv == 2'd3);
  end

  // Pulse monitor: sampled 1ns after the edge, so baud_tick still shows the tick of that edge
  always @(posedge sys_clk) begin
    #1;
    if (rec_ready === 1'b1) begin
      rdy_cnt++;
      got.push_back(rec_data);
      vectors++;
      if (baud_tick !== 1'b1 || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL pulse_timing: tick=%b frame_err=%b, required tick=1 frame_err=0", baud_tick, frame_err);
      end
    end
    if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt++;
`endif
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    repeat (64) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (64) @(negedge sys_clk);
    end
    if (PAR_EN) begin
      rx = (^b) ^ par_flip;
      repeat (64) @(negedge sys_clk);
    end
    rx = stop_bit;
    repeat (64) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_l = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge sys_clk);
    vectors++; if (rec_data !== 8'h00) begin errors++; $display("FAIL reset_rec_data: got %h, want 00", rec_data); end
    vectors++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL reset_rec_ready: got %b, want 0", rec_ready); end
    vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    sys_rst_l = 1'b0;
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic test_basic();
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (8) @(negedge sys_clk);
    vectors++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, want 1", rdy_cnt - r0); end
    vectors++; if (rec_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h, want a5", rec_data); end
    vectors++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr: got %0d, want 0", ferr_cnt - f0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, want 0", busy); end
  endtask

  task automatic test_glitch();
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(negedge sys_clk);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b, want 1", busy); end
    rx = 1'b1;
    repeat (40) @(negedge sys_clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b, want 0", busy); end
    vectors++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_rdy: got %0d, want 0", rdy_cnt - r0); end
    vectors++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d, want 0", ferr_cnt - f0); end
    repeat (40) @(negedge sys_clk);
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (160) @(negedge sys_clk);
    vectors++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d, want 1", ferr_cnt - f0); end
    vectors++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL ferr_rdy: got %0d, want 0", rdy_cnt - r0); end
    vectors++; if (rec_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h, want a5", rec_data); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b, want 1", busy); end
    rx = 1'b1;
    repeat (20) @(negedge sys_clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_release_busy: got %b, want 0", busy); end
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (8) @(negedge sys_clk);
    vectors++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL ferr_next_pulses: got %0d, want 1", rdy_cnt - r0); end
    vectors++; if (rec_data !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h, want 81", rec_data); end
    vectors++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_total: got %0d, want 1", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int r0, q0;
    r0 = rdy_cnt; q0 = got.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (8) @(negedge sys_clk);
    vectors++;
    if (rdy_cnt - r0 !== 3) begin
      errors++; $display("FAIL b2b_pulses: got %0d, want 3", rdy_cnt - r0);
    end else begin
      vectors++; if (got[q0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h, want 00", got[q0]); end
      vectors++; if (got[q0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h, want ff", got[q0+1]); end
      vectors++; if (got[q0+2] !== 8'h55) begin errors++; $display("FAIL b2b_byte2: got %h, want 55", got[q0+2]); end
    end
  endtask

  task automatic test_reset_mid();
    int r0, f0;
    logic [7:0] b;
    b = 8'hC3;
    r0 = rdy_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (64) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (64) @(negedge sys_clk);
    end
    rx = b[4];
    repeat (32) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
    sys_rst_l = 1'b0;
    rx = 1'b1;
    vectors++; if (rec_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h, want 00", rec_data); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, want 0", busy); end
    vectors++; if (rec_ready !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got rdy=%b ferr=%b, want 0 0", rec_ready, frame_err); end
    repeat (200) @(negedge sys_clk);
    vectors++; if (rdy_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rstmid_aborted: got rdy=%0d ferr=%0d, want 0 0", rdy_cnt - r0, ferr_cnt - f0); end
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (8) @(negedge sys_clk);
    vectors++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL rstmid_next_pulses: got %0d, want 1", rdy_cnt - r0); end
    vectors++; if (rec_data !== 8'h7E) begin errors++; $display("FAIL rstmid_next_data: got %h, want 7e", rec_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int r0, p0;
    r0 = rdy_cnt; p0 = perr_cnt;
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (8) @(negedge sys_clk);
    vectors++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL par_good_pulses: got %0d, want 1", rdy_cnt - r0); end
    vectors++; if (rec_data !== 8'h0F) begin errors++; $display("FAIL par_good_data: got %h, want 0f", rec_data); end
    vectors++; if (perr_cnt - p0 !== 0) begin errors++; $display("FAIL par_good_perr: got %0d, want 0", perr_cnt - p0); end
    send_frame(8'h0F, 1'b1, 1'b1);
    repeat (8) @(negedge sys_clk);
    vectors++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_bad_perr: got %0d, want 1", perr_cnt - p0); end
    vectors++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL par_bad_rdy: got %0d, want 1", rdy_cnt - r0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver that sits directly upstream of the byte-to-FIFO packing logic.
- Samples the serial line on a baud_tick strobe from the baud generator and assembles DATA-bit frames.
- For each valid frame, presents the byte on rec_data and a one-cycle rec_ready strobe.
- The packing controller consumes rec_data/rec_ready to fill its register array and push 64-bit words to the FIFO.

Parameters:
- DATA, 8, data bits per frame, sent LSB first.
- OS, 16, baud_tick strobes per bit period; even, ≥4.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_l  input  1  reset, synchronous, active-high (despite the _l suffix).
- baud_tick  input  1  one-sys_clk-wide strobe at OS × baud rate.
- rx  input  1  asynchronous serial line; idle high.
- rec_data  output  DATA  last correctly received byte.
- rec_ready  output  1  one-cycle pulse: rec_data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - rec_data = 0, rec_ready = 0, frame_err = 0, busy = 0.
  - Synchronizer flops = 1 (line idle).
  - FSM = IDLE; tick_cnt = 0; bit_cnt = 0.
- Synchronizer: rx passes through two flops to give rx_s. All decisions use rx_s only.
- Counters:
  - tick_cnt is $clog2(OS) bits wide and advances only on baud_tick.
  - bit_cnt is $clog2(DATA+1) bits wide.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rx_s = 0, go to START and clear tick_cnt. baud_tick is not required to leave IDLE.
- START: on each baud_tick, tick_cnt++. On the tick where tick_cnt = OS/2-1 (mid start bit):
  - rx_s = 0 → go to DATA, clear tick_cnt and bit_cnt.
  - rx_s = 1 → glitch; return to IDLE with no output.
- DATA: on each baud_tick, tick_cnt++. On the tick where tick_cnt = OS-1:
  - shift_reg = {rx_s, shift_reg[DATA-1:1]}; tick_cnt = 0; bit_cnt++.
  - After the DATA-th sample, go to STOP.
- STOP: on the tick where tick_cnt = OS-1:
  - rx_s = 1 → the next cycle, rec_data = shift_reg and rec_ready = 1 for exactly one cycle; go to IDLE.
  - rx_s = 0 → the next cycle, frame_err = 1 for one cycle; rec_data is unchanged; go to BREAK.
- BREAK: stay until rx_s = 1, then go to IDLE. This absorbs a line held low with no spurious start.
- rec_ready and frame_err are never both high in the same cycle.
- Latency: the pulse appears 1 sys_clk after the stop-bit sampling tick.
- Back-to-back frames: a start edge immediately after the stop sample is accepted, because IDLE is entered the same cycle.
- No backpressure: the consumer must accept rec_data within one frame time. rec_data is held until the next good frame.
- baud_tick on consecutive cycles is legal; each tick counts once.
- Reset mid-frame: the next cycle is fully at reset values; the partial byte is discarded with no pulse.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled at tick_cnt = OS-1.
  - Even parity over the DATA bits plus the parity bit.
  - Adds output parity_err (1 bit), reset 0.
  - On parity mismatch with a good stop bit, parity_err pulses for one cycle in place of rec_ready; rec_data is unchanged.
  - Framing error takes priority over parity error.
- Undefined: no PARITY state, no parity_err port; frame is 1 start + DATA data bits + 1 stop.

Test Plan:
- Send 0xA5 (OS=16, baud_tick every 4 sys_clk) → rec_ready pulses exactly once, 1 cycle after the stop sample; rec_data = 0xA5; frame_err stays 0.
- rx low for 5 ticks then high → no rec_ready and no frame_err; FSM back in IDLE; busy falls after the START check.
- Send 0x3C with stop bit forced 0, then hold rx low for 40 ticks → frame_err pulses once; rec_data keeps its previous value; no new frame while low; next frame 0x81 is received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three rec_ready pulses; rec_data sequence 0x00, 0xFF, 0x55.
- Assert sys_rst_l for 1 cycle at data bit 4 of 0xC3 → next cycle all outputs 0 and busy = 0; no pulse for the aborted byte; a following 0x7E is received correctly.
- With UART_RX_PARITY_EN: 0x0F with parity bit 0 → rec_ready pulses, rec_data = 0x0F. 0x0F with parity bit 1 → parity_err pulses; rec_ready stays 0.
